mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data memory between two requesters: the core's memory interface (port C: fetch, load/store) and the debug/program-loader port (port D).
- Sits between the core's address/data-out registers and the memory macro.
- Uses a round-robin request/grant handshake with a configurable memory read latency.
- Provides a debug halt that blocks new core accesses so the loader can own memory.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4). mem_rdata is valid MEM_LAT cycles after the mem_en cycle.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- c_req  in  1  core request; held until c_gnt is sampled high
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  one-cycle pulse: core access issued this cycle
- c_rvalid  out  1  one-cycle pulse: c_rdata valid
- c_rdata  out  DATA_W  core read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same directions and widths as the c_* ports, for the debug port
- dbg_halt  in  1  while high, c_req is masked
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0; FSM = IDLE; last_owner = D, so the core wins the first tie; latency counter = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - Eligible requests: c_req & ~dbg_halt, and d_req.
  - If none are eligible, stay in IDLE.
  - If exactly one is eligible, select it.
  - If both are eligible, select the port that is not last_owner.
  - On selection: latch owner, we, addr and wdata; set last_owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata = latched values.
  - Owner's gnt=1 this cycle only.
  - Write: next state IDLE.
  - Read: load counter with MEM_LAT-1; next state RD_WAIT.
- RD_WAIT:
  - mem_en=0.
  - When counter==0: capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement the counter.
- RESP (1 cycle): owner's rvalid=1; next state IDLE.
- Latency, where E is the ISSUE cycle:
  - Request seen in IDLE at cycle N → issue at E=N+1.
  - Read data on the owner's rdata with rvalid at E+MEM_LAT+1.
  - Minimum spacing: writes every 2 cycles; reads every MEM_LAT+3 cycles.
- rdata holds its last value until the next read for that port. The non-owner's rvalid and gnt stay 0.
- A requester may change addr/we/wdata only after sampling gnt. It may re-assert req in the cycle after gnt.
- dbg_halt:
  - An in-flight core access (ISSUE/RD_WAIT/RESP) completes normally.
  - Halt only affects arbitration in IDLE.
  - Deasserting halt re-enables the core from the next IDLE cycle.
- Only one request is accepted per IDLE visit. Simultaneous requests always produce exactly one gnt.
- A request that drops before gnt is a protocol violation. No recovery is required; an already latched access still completes.
- Reset mid-operation: FSM returns to IDLE and all outputs go to 0 in the next cycle. An in-flight read produces no rvalid. Memory content written before reset is unaffected.
- mem_en is never high in two consecutive cycles.

Test Plan:
- Reset, then c_req=1, c_we=0, c_addr=0x10, MEM_LAT=1, mem returns 0xE1A00000 → c_gnt at cycle 2, mem_en/mem_addr=0x10 at cycle 2, c_rvalid=1 with c_rdata=0xE1A00000 at cycle 4; d_* outputs stay 0.
- c_req and d_req held high together for 4 accesses after reset → grant order C, D, C, D; never both gnt in one cycle.
- dbg_halt=1 with both requesting writes (D: addr 0x20, data 0xDEADBEEF) → only d_gnt pulses; mem_we=1, mem_wdata=0xDEADBEEF; c_gnt stays 0 until halt drops, then C is granted in the next IDLE.
- MEM_LAT=3, core read at 0x04 → c_rvalid exactly 4 cycles after the mem_en cycle; a d_req raised during RD_WAIT is granted only after RESP.
- Reset asserted in RD_WAIT → no c_rvalid, busy=0 and all outputs 0 next cycle; a new read after reset completes normally.
- Back-to-back core writes to 0x0..0xC → mem_en pulses every 2 cycles and never in consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (core C, debug/loader D), the shared
// single-port memory macro and the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              dbg_halt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  dbg_halt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output dbg_halt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the core (C) and
// the debug/loader port (D); every output is registered.
//
// state   | meaning
// IDLE    | arbitrate; dbg_halt masks the core request
// ISSUE   | mem_en high for one cycle, owner's gnt pulses
// RD_WAIT | waiting MEM_LAT cycles for mem_rdata
// RESP    | owner's rvalid pulses with captured read data
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1    // legal 1..4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner_d_q, owner_d_nxt;
  logic              last_d_q, last_d_nxt;
  logic [1:0]        cnt_q, cnt_nxt;

  logic              c_gnt_q, c_gnt_nxt;
  logic              d_gnt_q, d_gnt_nxt;
  logic              c_rvalid_q, c_rvalid_nxt;
  logic              d_rvalid_q, d_rvalid_nxt;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
  logic              mem_en_q, mem_en_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic              busy_q, busy_nxt;

  logic              c_elig, d_elig, pick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_d_q   <= 1'b0;
      last_d_q    <= 1'b1;
      cnt_q       <= 2'd0;
      c_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner_d_q   <= owner_d_nxt;
      last_d_q    <= last_d_nxt;
      cnt_q       <= cnt_nxt;
      c_gnt_q     <= c_gnt_nxt;
      d_gnt_q     <= d_gnt_nxt;
      c_rvalid_q  <= c_rvalid_nxt;
      d_rvalid_q  <= d_rvalid_nxt;
      c_rdata_q   <= c_rdata_nxt;
      d_rdata_q   <= d_rdata_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Outputs are computed from the next state so that the registered strobes
  // line up with the state they belong to (gnt/mem_en in ISSUE, rvalid in RESP).
  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d_q;
    last_d_nxt    = last_d_q;
    cnt_nxt       = cnt_q;
    c_gnt_nxt     = 1'b0;
    d_gnt_nxt     = 1'b0;
    c_rvalid_nxt  = 1'b0;
    d_rvalid_nxt  = 1'b0;
    c_rdata_nxt   = c_rdata_q;
    d_rdata_nxt   = d_rdata_q;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    c_elig        = bus.c_req & ~bus.dbg_halt;
    d_elig        = bus.d_req;
    pick_d        = d_elig & (~c_elig | ~last_d_q);

    case (state)
      IDLE: begin
        if (c_elig | d_elig) begin
          owner_d_nxt   = pick_d;
          last_d_nxt    = pick_d;
          state_nxt     = ISSUE;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = pick_d ? bus.d_we    : bus.c_we;
          mem_addr_nxt  = pick_d ? bus.d_addr  : bus.c_addr;
          mem_wdata_nxt = pick_d ? bus.d_wdata : bus.c_wdata;
          c_gnt_nxt     = ~pick_d;
          d_gnt_nxt     = pick_d;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = 2'(MEM_LAT - 1);
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_d_q) begin
            d_rdata_nxt  = bus.mem_rdata;
            d_rvalid_nxt = 1'b1;
          end else begin
            c_rdata_nxt  = bus.mem_rdata;
            c_rvalid_nxt = 1'b1;
          end
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.c_gnt     = c_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with
// MEM_LAT=3, each backed by a small memory model with a tagged read pipeline.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  // Memory models: read data is only meaningful exactly MEM_LAT cycles after
  // the mem_en cycle; any other cycle returns a poison pattern.
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] p1_d;
  logic        p1_v;
  logic [31:0] p3_d [0:2];
  logic [2:0]  p3_v;

  always @(posedge clk) begin
    if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr[7:2]] <= if1.mem_wdata;
    p1_v <= if1.mem_en && !if1.mem_we;
    p1_d <= mem1[if1.mem_addr[7:2]];
    if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr[7:2]] <= if3.mem_wdata;
    p3_v    <= {p3_v[1:0], if3.mem_en && !if3.mem_we};
    p3_d[0] <= mem3[if3.mem_addr[7:2]];
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end

  assign if1.mem_rdata = p1_v    ? p1_d    : 32'hBAD0_BAD0;
  assign if3.mem_rdata = p3_v[2] ? p3_d[2] : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int   ngnt;
  logic both;
  logic order [0:3];
  int   idx;
  int   last_g;
  logic prev_en;
  logic consec;
  logic gap_bad;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem1[4] = 32'hE1A0_0000;
    mem3[1] = 32'hA5A5_0004;
    mem3[2] = 32'h5A5A_0008;
    mem3[3] = 32'hC0DE_000C;
    p1_v = 1'b0;
    p3_v = 3'b000;
    {if1.c_req, if1.c_we, if1.d_req, if1.d_we, if1.dbg_halt} = '0;
    {if3.c_req, if3.c_we, if3.d_req, if3.d_we, if3.dbg_halt} = '0;
    if1.c_addr = '0; if1.c_wdata = '0; if1.d_addr = '0; if1.d_wdata = '0;
    if3.c_addr = '0; if3.c_wdata = '0; if3.d_addr = '0; if3.d_wdata = '0;
    reset = 1'b1;
    repeat (3) step();

    chk("rst_busy",    if1.busy,     1'b0);
    chk("rst_mem_en",  if1.mem_en,   1'b0);
    chk("rst_c_gnt",   if1.c_gnt,    1'b0);
    chk("rst_d_rvalid",if1.d_rvalid, 1'b0);
    chk("rst_c_rdata", if1.c_rdata,  32'h0);

    // Single core read, MEM_LAT=1
    reset = 1'b0;
    if1.c_req = 1'b1; if1.c_we = 1'b0; if1.c_addr = 32'h10;
    step();
    chk("t1_c_gnt",    if1.c_gnt,    1'b1);
    chk("t1_mem_en",   if1.mem_en,   1'b1);
    chk("t1_mem_addr", if1.mem_addr, 32'h10);
    chk("t1_mem_we",   if1.mem_we,   1'b0);
    chk("t1_d_gnt",    if1.d_gnt,    1'b0);
    chk("t1_busy",     if1.busy,     1'b1);
    if1.c_req = 1'b0;
    step();
    chk("t1_gnt_pulse",   if1.c_gnt,    1'b0);
    chk("t1_mem_en_off",  if1.mem_en,   1'b0);
    chk("t1_rvalid_early",if1.c_rvalid, 1'b0);
    step();
    chk("t1_c_rvalid", if1.c_rvalid, 1'b1);
    chk("t1_c_rdata",  if1.c_rdata,  32'hE1A0_0000);
    chk("t1_d_rvalid", if1.d_rvalid, 1'b0);
    chk("t1_d_rdata",  if1.d_rdata,  32'h0);
    step();
    chk("t1_rvalid_pulse", if1.c_rvalid, 1'b0);
    chk("t1_rdata_hold",   if1.c_rdata,  32'hE1A0_0000);
    chk("t1_idle_busy",    if1.busy,     1'b0);

    // Round robin with both ports writing continuously
    reset = 1'b1;
    step();
    reset = 1'b0;
    if1.c_req = 1'b1; if1.c_we = 1'b1; if1.c_addr = 32'h40; if1.c_wdata = 32'hC0;
    if1.d_req = 1'b1; if1.d_we = 1'b1; if1.d_addr = 32'h44; if1.d_wdata = 32'hD0;
    ngnt = 0;
    both = 1'b0;
    for (int cyc = 0; cyc < 20 && ngnt < 4; cyc++) begin
      step();
      if (if1.c_gnt && if1.d_gnt) both = 1'b1;
      if (if1.c_gnt) begin
        order[ngnt] = 1'b0;
        ngnt++;
      end else if (if1.d_gnt) begin
        order[ngnt] = 1'b1;
        ngnt++;
      end
    end
    chk("t2_gnt_count", ngnt, 4);
    chk("t2_both_gnt",  both, 1'b0);
    chk("t2_order0", order[0], 1'b0);
    chk("t2_order1", order[1], 1'b1);
    chk("t2_order2", order[2], 1'b0);
    chk("t2_order3", order[3], 1'b1);
    if1.c_req = 1'b0; if1.d_req = 1'b0;
    step();
    chk("t2_mem_d", mem1[17], 32'hD0);
    chk("t2_mem_c", mem1[16], 32'hC0);
    step();

    // dbg_halt masks the core; loader write goes through
    if1.dbg_halt = 1'b1;
    if1.c_req = 1'b1; if1.c_we = 1'b1; if1.c_addr = 32'h30; if1.c_wdata = 32'h1111_1111;
    if1.d_req = 1'b1; if1.d_we = 1'b1; if1.d_addr = 32'h20; if1.d_wdata = 32'hDEAD_BEEF;
    step();
    chk("t3_d_gnt",     if1.d_gnt,     1'b1);
    chk("t3_c_gnt",     if1.c_gnt,     1'b0);
    chk("t3_mem_we",    if1.mem_we,    1'b1);
    chk("t3_mem_wdata", if1.mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_addr",  if1.mem_addr,  32'h20);
    if1.d_req = 1'b0;
    step();
    chk("t3_c_halted1", if1.c_gnt, 1'b0);
    step();
    chk("t3_c_halted2", if1.c_gnt, 1'b0);
    chk("t3_mem_write", mem1[8], 32'hDEAD_BEEF);
    if1.dbg_halt = 1'b0;
    step();
    chk("t3_c_gnt_after", if1.c_gnt,    1'b1);
    chk("t3_c_addr_after",if1.mem_addr, 32'h30);
    if1.c_req = 1'b0;
    step();
    step();

    // MEM_LAT=3 core read; loader request during RD_WAIT waits for RESP
    if3.c_req = 1'b1; if3.c_we = 1'b0; if3.c_addr = 32'h04;
    step();
    chk("t4_c_gnt",  if3.c_gnt,  1'b1);
    chk("t4_mem_en", if3.mem_en, 1'b1);
    if3.c_req = 1'b0;
    step();
    chk("t4_mem_en_off", if3.mem_en, 1'b0);
    if3.d_req = 1'b1; if3.d_we = 1'b0; if3.d_addr = 32'h08;
    step();
    chk("t4_rv_e2", if3.c_rvalid, 1'b0);
    step();
    chk("t4_rv_e3",   if3.c_rvalid, 1'b0);
    chk("t4_dgnt_e3", if3.d_gnt,    1'b0);
    step();
    chk("t4_c_rvalid", if3.c_rvalid, 1'b1);
    chk("t4_c_rdata",  if3.c_rdata,  32'hA5A5_0004);
    chk("t4_dgnt_e4",  if3.d_gnt,    1'b0);
    step();
    chk("t4_dgnt_e5",  if3.d_gnt,    1'b0);
    chk("t4_rv_e5",    if3.c_rvalid, 1'b0);
    step();
    chk("t4_dgnt_e6",  if3.d_gnt,    1'b1);
    if3.d_req = 1'b0;
    repeat (3) step();
    chk("t4_d_rv_early", if3.d_rvalid, 1'b0);
    step();
    chk("t4_d_rvalid",  if3.d_rvalid, 1'b1);
    chk("t4_d_rdata",   if3.d_rdata,  32'h5A5A_0008);
    chk("t4_c_rdata_hold", if3.c_rdata, 32'hA5A5_0004);
    step();

    // Reset during RD_WAIT kills the read
    if3.c_req = 1'b1; if3.c_we = 1'b0; if3.c_addr = 32'h0C;
    step();
    chk("t5_c_gnt", if3.c_gnt, 1'b1);
    if3.c_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("t5_busy",    if3.busy,     1'b0);
    chk("t5_rvalid",  if3.c_rvalid, 1'b0);
    chk("t5_mem_en",  if3.mem_en,   1'b0);
    chk("t5_c_rdata", if3.c_rdata,  32'h0);
    chk("t5_d_rdata", if3.d_rdata,  32'h0);
    reset = 1'b0;
    step();
    chk("t5_no_rv1", if3.c_rvalid, 1'b0);
    step();
    chk("t5_no_rv2", if3.c_rvalid, 1'b0);
    if3.c_req = 1'b1;
    step();
    chk("t5_regnt", if3.c_gnt, 1'b1);
    if3.c_req = 1'b0;
    repeat (3) step();
    chk("t5_rv_early", if3.c_rvalid, 1'b0);
    step();
    chk("t5_rvalid_new", if3.c_rvalid, 1'b1);
    chk("t5_rdata_new",  if3.c_rdata,  32'hC0DE_000C);

    // Back-to-back core writes to 0x0..0xC
    idx = 0;
    last_g = -1;
    prev_en = 1'b0;
    consec = 1'b0;
    gap_bad = 1'b0;
    if1.c_req = 1'b1; if1.c_we = 1'b1; if1.c_addr = 32'h0; if1.c_wdata = 32'h100;
    for (int cyc = 0; cyc < 30 && idx < 4; cyc++) begin
      step();
      if (if1.mem_en && prev_en) consec = 1'b1;
      prev_en = if1.mem_en;
      if (if1.c_gnt) begin
        if (idx > 0 && cyc - last_g != 2) gap_bad = 1'b1;
        last_g = cyc;
        idx++;
        if (idx < 4) begin
          if1.c_addr  = 32'(idx * 4);
          if1.c_wdata = 32'(32'h100 + idx);
        end else begin
          if1.c_req = 1'b0;
        end
      end
    end
    step();
    if (if1.mem_en && prev_en) consec = 1'b1;
    chk("t6_count",   idx,     4);
    chk("t6_consec",  consec,  1'b0);
    chk("t6_spacing", gap_bad, 1'b0);
    chk("t6_mem0", mem1[0], 32'h100);
    chk("t6_mem1", mem1[1], 32'h101);
    chk("t6_mem2", mem1[2], 32'h102);
    chk("t6_mem3", mem1[3], 32'h103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
